chrono_button_control: RTL and testbench

Front-end control stage for the stopwatch: debounces the two push-buttons, runs the start/stop/lap/clear state machine, and gates the 100 Hz time-base tick before it reaches the centi-second counter chain. Outputs drive the counters' count enable and synchronous clear, and the display mux's freeze (lap hold). One clock domain, CLK_50M.

---
 rtl/chrono_button_control.sv | 164 ++++++++++++++++
 tb/tb_chrono_button_control.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chrono_button_control.sv
// rtl/chrono_button_control.sv - stopwatch button debounce, start/stop/lap/clear FSM and tick gating

// Synchroniser, debouncer and press detector for one raw push-button.
module chrono_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser, then accept a level change only after it has
  // persisted DEBOUNCE_CYCLES consecutive cycles; any return to the stable
  // level discards the partial count.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 != stable) begin
        if (cnt == LAST) begin
          stable <= ~stable;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Press is the single cycle where the debounced level has just gone high.
  assign press = stable & ~stable_d;

endmodule

// Top: two debounced buttons drive the stopwatch mode FSM.
module chrono_button_control #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       btn_start_stop,
  input  logic       btn_lap_clear,
  input  logic       tick_in,
  output logic       tick_out,
  output logic       run,
  output logic       clear,
  output logic       freeze,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUNNING = 2'b01,
    S_LAP     = 2'b10,
    S_STOPPED = 2'b11
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   nxt_clear;
  logic   ss_press;
  logic   lc_press;
  logic   ss_evt;
  logic   lc_evt;

  chrono_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .btn_raw (btn_start_stop),
    .press   (ss_press)
  );

  chrono_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lc (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .btn_raw (btn_lap_clear),
    .press   (lc_press)
  );

  // Start/stop has priority: a lap/clear press in the same cycle is dropped.
  assign ss_evt = ss_press;
  assign lc_evt = lc_press & ~ss_press;

  // Next-state and clear-request decode.
  always_comb begin
    nxt_state = cur_state;
    nxt_clear = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (ss_evt) begin
          nxt_state = S_RUNNING;
        end else if (lc_evt) begin
          nxt_clear = 1'b1;
        end
      end
      S_RUNNING: begin
        if (ss_evt) begin
          nxt_state = S_STOPPED;
        end else if (lc_evt) begin
          nxt_state = S_LAP;
        end
      end
      S_LAP: begin
        if (ss_evt) begin
          nxt_state = S_STOPPED;
        end else if (lc_evt) begin
          nxt_state = S_RUNNING;
        end
      end
      S_STOPPED: begin
        if (ss_evt) begin
          nxt_state = S_RUNNING;
        end else if (lc_evt) begin
          nxt_state = S_IDLE;
          nxt_clear = 1'b1;
        end
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  // State register with outputs registered alongside it; tick gating uses
  // the pre-update run value so a tick coinciding with a mode change follows
  // the old mode.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cur_state <= S_IDLE;
      run       <= 1'b0;
      freeze    <= 1'b0;
      clear     <= 1'b0;
      tick_out  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      run       <= (nxt_state == S_RUNNING) || (nxt_state == S_LAP);
      freeze    <= (nxt_state == S_LAP);
      clear     <= nxt_clear;
      tick_out  <= tick_in & run;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_chrono_button_control.sv
// tb/tb_chrono_button_control.sv - self-checking bench for chrono_button_control

module tb_chrono_button_control;

  localparam int DB = 4;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUNS = 2'b01;
  localparam logic [1:0] LAP  = 2'b10;
  localparam logic [1:0] STOP = 2'b11;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       btn_start_stop;
  logic       btn_lap_clear;
  logic       tick_in;
  logic       tick_out;
  logic       run;
  logic       clear;
  logic       freeze;
  logic [1:0] state;

  int         checks = 0;
  int         errors = 0;
  logic [5:0] exp_q[$];
  logic       cur_run;

  chrono_button_control #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .btn_start_stop (btn_start_stop),
    .btn_lap_clear  (btn_lap_clear),
    .tick_in        (tick_in),
    .tick_out       (tick_out),
    .run            (run),
    .clear          (clear),
    .freeze         (freeze),
    .state          (state)
  );

  always #5 clk_in = ~clk_in;

  // Expected {state, run, freeze, clear, tick_out} for a given state.
  function automatic logic [5:0] pk(input logic [1:0] s, input logic c, input logic t);
    return {s, (s == RUNS) || (s == LAP), s == LAP, c, t};
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    logic [5:0] want;
    rst_in = 1'b1;
    btn_start_stop = 1'b0;
    btn_lap_clear = 1'b0;
    tick_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(6'b0);
      cyc();
      want = exp_q.pop_front();
      got = {state, run, freeze, clear, tick_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset c%0d got %b want %b", i, got, want);
      end
    end
    rst_in = 1'b0;
    tick_in = 1'b0;
    cur_run = 1'b0;
  endtask

  task automatic test_start();
    logic [1:0] es;
    logic [5:0] got;
    logic [5:0] want;
    for (int i = 0; i < 20; i++) begin
      es = (i + 1 >= 7) ? RUNS : IDLE;
      btn_start_stop = (i < 10);
      btn_lap_clear = 1'b0;
      tick_in = 1'b1;
      exp_q.push_back(pk(es, 1'b0, cur_run));
      cur_run = (es == RUNS) || (es == LAP);
      cyc();
      want = exp_q.pop_front();
      got = {state, run, freeze, clear, tick_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL start e%0d got %b want %b", i + 1, got, want);
      end
    end
  endtask

  task automatic test_bounce_stop();
    logic [1:0] es;
    logic       tk;
    logic [5:0] got;
    logic [5:0] want;
    for (int i = 0; i < 32; i++) begin
      es = (i + 1 >= 21) ? STOP : RUNS;
      tk = 1'($urandom_range(0, 1));
      btn_start_stop = (i <= 2) || (i >= 4 && i <= 6) || (i >= 14 && i <= 19);
      btn_lap_clear = 1'b0;
      tick_in = tk;
      exp_q.push_back(pk(es, 1'b0, tk & cur_run));
      cur_run = (es == RUNS) || (es == LAP);
      cyc();
      want = exp_q.pop_front();
      got = {state, run, freeze, clear, tick_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bounce_stop e%0d got %b want %b", i + 1, got, want);
      end
    end
  endtask

  task automatic test_lap();
    logic [1:0] es;
    logic       tk;
    logic [5:0] got;
    logic [5:0] want;
    for (int i = 0; i < 66; i++) begin
      if (i + 1 < 7)       es = STOP;
      else if (i + 1 < 19) es = RUNS;
      else if (i + 1 < 31) es = LAP;
      else if (i + 1 < 45) es = RUNS;
      else if (i + 1 < 57) es = LAP;
      else                 es = STOP;
      tk = 1'($urandom_range(0, 1));
      btn_start_stop = (i < 6) || (i >= 50 && i < 56);
      btn_lap_clear = (i >= 12 && i < 18) || (i >= 24 && i < 30) || (i >= 38 && i < 44);
      tick_in = tk;
      exp_q.push_back(pk(es, 1'b0, tk & cur_run));
      cur_run = (es == RUNS) || (es == LAP);
      cyc();
      want = exp_q.pop_front();
      got = {state, run, freeze, clear, tick_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL lap e%0d got %b want %b", i + 1, got, want);
      end
    end
  endtask

  task automatic test_clear();
    logic [1:0] es;
    logic       tk;
    logic [5:0] got;
    logic [5:0] want;
    for (int i = 0; i < 26; i++) begin
      es = (i + 1 >= 7) ? IDLE : STOP;
      tk = 1'($urandom_range(0, 1));
      btn_start_stop = 1'b0;
      btn_lap_clear = (i < 6) || (i >= 12 && i < 18);
      tick_in = tk;
      exp_q.push_back(pk(es, (i + 1 == 7) || (i + 1 == 19), tk & cur_run));
      cur_run = (es == RUNS) || (es == LAP);
      cyc();
      want = exp_q.pop_front();
      got = {state, run, freeze, clear, tick_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL clear e%0d got %b want %b", i + 1, got, want);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] es;
    logic       tk;
    logic [5:0] got;
    logic [5:0] want;
    for (int i = 0; i < 26; i++) begin
      if (i + 1 < 7)       es = IDLE;
      else if (i + 1 < 19) es = RUNS;
      else                 es = STOP;
      tk = 1'($urandom_range(0, 1));
      btn_start_stop = (i < 6) || (i >= 12 && i < 18);
      btn_lap_clear = (i >= 12 && i < 18);
      tick_in = tk;
      exp_q.push_back(pk(es, 1'b0, tk & cur_run));
      cur_run = (es == RUNS) || (es == LAP);
      cyc();
      want = exp_q.pop_front();
      got = {state, run, freeze, clear, tick_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL simultaneous e%0d got %b want %b", i + 1, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [1:0] es;
    logic [5:0] got;
    logic [5:0] want;
    for (int i = 0; i < 24; i++) begin
      if (i + 1 < 4)       es = STOP;
      else if (i + 1 < 11) es = IDLE;
      else                 es = RUNS;
      btn_start_stop = (i < 15);
      btn_lap_clear = 1'b0;
      rst_in = (i == 3);
      tick_in = 1'b1;
      exp_q.push_back(pk(es, 1'b0, (i + 1 == 4) ? 1'b0 : cur_run));
      cur_run = (es == RUNS) || (es == LAP);
      cyc();
      want = exp_q.pop_front();
      got = {state, run, freeze, clear, tick_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid e%0d got %b want %b", i + 1, got, want);
      end
    end
    rst_in = 1'b0;
    tick_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    btn_start_stop = 1'b0;
    btn_lap_clear = 1'b0;
    tick_in = 1'b0;
    cur_run = 1'b0;
    test_reset();
    test_start();
    test_bounce_stop();
    test_lap();
    test_clear();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
